// File: rtl/cgram_cpu_port_if.sv
// B-bus palette register port and CGRAM port-A signals between the CPU side and
// the palette access controller.
interface cgram_cpu_port_if;
   logic        reg_wr;
   logic        reg_rd;
   logic [7:0]  reg_addr;
   logic [7:0]  reg_wdata;
   logic [7:0]  open_bus;
   logic        active_disp;
   logic [7:0]  reg_rdata;
   logic        rd_valid;
   logic        busy;
   logic        ram_ce;
   logic        ram_wre;
   logic [7:0]  ram_ad;
   logic [14:0] ram_din;
   logic [14:0] ram_dout;
   logic        ram_oce;

   modport slave (
      input  reg_wr, reg_rd, reg_addr, reg_wdata, open_bus, active_disp, ram_dout,
      output reg_rdata, rd_valid, busy, ram_ce, ram_wre, ram_ad, ram_din, ram_oce
   );

   modport master (
      output reg_wr, reg_rd, reg_addr, reg_wdata, open_bus, active_disp, ram_dout,
      input  reg_rdata, rd_valid, busy, ram_ce, ram_wre, ram_ad, ram_din, ram_oce
   );
endinterface

// File: rtl/cgram_cpu_port.sv
// CPU-side CGRAM access controller: decodes $2121/$2122/$213B and drives CGRAM port A.
// Optional build macro CGRAM_DISP_GUARD_EN blocks palette RAM writes during active display.
module cgram_cpu_port (
   input logic               clk,
   input logic               resetn,
   cgram_cpu_port_if.slave   bus
);

   localparam logic [7:0] AddrCgadd  = 8'h21;
   localparam logic [7:0] AddrCgdata = 8'h22;
   localparam logic [7:0] AddrRdcgram = 8'h3B;

   typedef enum logic [1:0] {StIdle, StRdIssue, StRdCapt} state_e;

   state_e      r_state;
   logic [7:0]  r_cgadd;
   logic        r_flip;
   logic [7:0]  r_wlatch;
   logic [7:0]  r_reg_rdata;
   logic        r_rd_valid;
   logic        r_busy;
   logic        r_ram_ce;
   logic        r_ram_wre;
   logic [7:0]  r_ram_ad;
   logic [14:0] r_ram_din;

   logic        w_wr_block;
   logic        w_unused;

`ifdef CGRAM_DISP_GUARD_EN
   assign w_wr_block = bus.active_disp;
   assign w_unused   = ^{bus.open_bus[6:0], bus.reg_wdata[7]};
`else
   assign w_wr_block = 1'b0;
   assign w_unused   = ^{bus.open_bus[6:0], bus.reg_wdata[7], bus.active_disp};
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= StIdle;
         r_cgadd     <= 8'h00;
         r_flip      <= 1'b0;
         r_wlatch    <= 8'h00;
         r_reg_rdata <= 8'h00;
         r_rd_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_ram_ce    <= 1'b0;
         r_ram_wre   <= 1'b0;
         r_ram_ad    <= 8'h00;
         r_ram_din   <= 15'h0000;
      end else begin
         r_ram_ce   <= 1'b0;
         r_ram_wre  <= 1'b0;
         r_rd_valid <= 1'b0;
         unique case (r_state)
            StIdle: begin
               // Write wins over a simultaneous read; the read is simply dropped.
               if (bus.reg_wr) begin
                  if (bus.reg_addr == AddrCgadd) begin
                     r_cgadd <= bus.reg_wdata;
                     r_flip  <= 1'b0;
                  end else if (bus.reg_addr == AddrCgdata) begin
                     if (!r_flip) begin
                        r_wlatch <= bus.reg_wdata;
                        r_flip   <= 1'b1;
                     end else begin
                        r_ram_ce  <= ~w_wr_block;
                        r_ram_wre <= ~w_wr_block;
                        r_ram_ad  <= r_cgadd;
                        r_ram_din <= {bus.reg_wdata[6:0], r_wlatch};
                        r_cgadd   <= r_cgadd + 8'd1;
                        r_flip    <= 1'b0;
                     end
                  end
               end else if (bus.reg_rd && (bus.reg_addr == AddrRdcgram)) begin
                  r_state  <= StRdIssue;
                  r_busy   <= 1'b1;
                  r_ram_ce <= 1'b1;
                  r_ram_ad <= r_cgadd;
               end
            end
            StRdIssue: begin
               r_state <= StRdCapt;
            end
            StRdCapt: begin
               r_state    <= StIdle;
               r_busy     <= 1'b0;
               r_rd_valid <= 1'b1;
               if (!r_flip) begin
                  r_reg_rdata <= bus.ram_dout[7:0];
                  r_flip      <= 1'b1;
               end else begin
                  r_reg_rdata <= {bus.open_bus[7], bus.ram_dout[14:8]};
                  r_flip      <= 1'b0;
                  r_cgadd     <= r_cgadd + 8'd1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.reg_rdata = r_reg_rdata;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.busy      = r_busy;
   assign bus.ram_ce    = r_ram_ce;
   assign bus.ram_wre   = r_ram_wre;
   assign bus.ram_ad    = r_ram_ad;
   assign bus.ram_din   = r_ram_din;
   assign bus.ram_oce   = 1'b1;

endmodule

// File: tb/tb_cgram_cpu_port.sv
// Directed bench for cgram_cpu_port with a one-cycle-latency CGRAM port-A model.
module tb_cgram_cpu_port;

   logic clk;
   logic resetn;
   int   n_checks;
   int   n_pass;

   logic        s_ce;
   logic        s_wre;
   logic [7:0]  s_ad;
   logic [14:0] s_din;

   logic [14:0] mem [256];

   cgram_cpu_port_if bus ();

   cgram_cpu_port u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.ram_ce) begin
         if (bus.ram_wre) mem[bus.ram_ad] <= bus.ram_din;
         bus.ram_dout <= mem[bus.ram_ad];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   // Strobe for one cycle, return mid-way through the following cycle with port A sampled.
   task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
      bus.reg_wr    = 1'b1;
      bus.reg_addr  = a;
      bus.reg_wdata = d;
      @(negedge clk);
      bus.reg_wr = 1'b0;
      s_ce  = bus.ram_ce;
      s_wre = bus.ram_wre;
      s_ad  = bus.ram_ad;
      s_din = bus.ram_din;
   endtask

   task automatic bus_rd(input logic [7:0] exp_ad, input logic [7:0] exp_data);
      bus.reg_rd   = 1'b1;
      bus.reg_addr = 8'h3B;
      @(negedge clk);
      bus.reg_rd = 1'b0;
      check("rd_n1_busy", bus.busy, 1);
      check("rd_n1_ce", bus.ram_ce, 1);
      check("rd_n1_wre", bus.ram_wre, 0);
      check("rd_n1_ad", bus.ram_ad, exp_ad);
      @(negedge clk);
      check("rd_n2_busy", bus.busy, 1);
      check("rd_n2_valid", bus.rd_valid, 0);
      check("rd_n2_ce", bus.ram_ce, 0);
      @(negedge clk);
      check("rd_n3_valid", bus.rd_valid, 1);
      check("rd_n3_busy", bus.busy, 0);
      check("rd_n3_data", bus.reg_rdata, exp_data);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      for (int i = 0; i < 256; i++) mem[i] = 15'h0000;
      mem[8'h05] = 15'h7ABC;
      mem[8'h06] = 15'h1357;
      mem[8'h30] = 15'h0F0F;
      bus.ram_dout    = 15'h0000;
      resetn          = 1'b0;
      bus.reg_wr      = 1'b0;
      bus.reg_rd      = 1'b0;
      bus.reg_addr    = 8'h00;
      bus.reg_wdata   = 8'h00;
      bus.open_bus    = 8'h00;
      bus.active_disp = 1'b0;
      repeat (2) @(negedge clk);

      check("rst_rdata", bus.reg_rdata, 0);
      check("rst_valid", bus.rd_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ce", bus.ram_ce, 0);
      check("rst_wre", bus.ram_wre, 0);
      check("rst_ad", bus.ram_ad, 0);
      check("rst_din", bus.ram_din, 0);
      check("oce", bus.ram_oce, 1);
      resetn = 1'b1;
      @(negedge clk);

      // Basic pair write
      bus_wr(8'h21, 8'h10);
      check("w21_ce", s_ce, 0);
      bus_wr(8'h22, 8'h1F);
      check("w22lo_ce", s_ce, 0);
      bus_wr(8'h22, 8'hFC);
      check("w1_ce", s_ce, 1);
      check("w1_wre", s_wre, 1);
      check("w1_ad", s_ad, 8'h10);
      check("w1_din", s_din, 15'h7C1F);
      @(negedge clk);
      check("w1_ce_drop", bus.ram_ce, 0);
      check("mem10", mem[8'h10], 15'h7C1F);
      // Back-to-back pair confirms the address advanced to 0x11
      bus_wr(8'h22, 8'hAA);
      bus_wr(8'h22, 8'h55);
      check("w2_ad", s_ad, 8'h11);
      check("w2_din", s_din, 15'h55AA);

      // Address wrap
      bus_wr(8'h21, 8'hFF);
      bus_wr(8'h22, 8'h34);
      bus_wr(8'h22, 8'h12);
      check("wff_ad", s_ad, 8'hFF);
      check("wff_din", s_din, 15'h1234);
      bus_wr(8'h22, 8'h01);
      bus_wr(8'h22, 8'h00);
      check("wrap_ad", s_ad, 8'h00);
      check("wrap_din", s_din, 15'h0001);
      @(negedge clk);
      check("memff", mem[8'hFF], 15'h1234);
      check("mem00", mem[8'h00], 15'h0001);

      // Reads: low byte, then open-bus bit 7 plus high bits, address advances
      bus.open_bus = 8'h80;
      bus_wr(8'h21, 8'h05);
      bus_rd(8'h05, 8'hBC);
      bus_rd(8'h05, 8'hFA);
      @(negedge clk);
      check("rd_valid_pulse", bus.rd_valid, 0);
      bus.open_bus = 8'h7F;
      bus_rd(8'h06, 8'h57);
      bus_rd(8'h06, 8'h13);

      // A stray low byte is discarded by the $21 write
      bus_wr(8'h22, 8'h11);
      bus_wr(8'h21, 8'h20);
      bus_wr(8'h22, 8'h22);
      bus_wr(8'h22, 8'h33);
      check("flip_ad", s_ad, 8'h20);
      check("flip_din", s_din, 15'h3322);
      @(negedge clk);
      check("mem20", mem[8'h20], 15'h3322);

      // Write strobe while busy must be dropped
      bus_wr(8'h21, 8'h30);
      bus.reg_rd   = 1'b1;
      bus.reg_addr = 8'h3B;
      @(negedge clk);
      bus.reg_rd    = 1'b0;
      bus.reg_wr    = 1'b1;
      bus.reg_addr  = 8'h22;
      bus.reg_wdata = 8'h99;
      check("drop_busy", bus.busy, 1);
      @(negedge clk);
      bus.reg_wr = 1'b0;
      check("drop_ce", bus.ram_ce, 0);
      @(negedge clk);
      check("drop_valid", bus.rd_valid, 1);
      check("drop_rdata", bus.reg_rdata, 8'h0F);
      bus_wr(8'h22, 8'h44);
      check("drop_w_ce", s_ce, 1);
      check("drop_w_ad", s_ad, 8'h30);
      check("drop_w_din", s_din, 15'h4422);

      // Simultaneous write and read strobes: read is dropped
      bus.reg_wr    = 1'b1;
      bus.reg_rd    = 1'b1;
      bus.reg_addr  = 8'h3B;
      bus.reg_wdata = 8'h00;
      @(negedge clk);
      bus.reg_wr = 1'b0;
      bus.reg_rd = 1'b0;
      check("both_busy", bus.busy, 0);
      check("both_ce", bus.ram_ce, 0);
      repeat (2) @(negedge clk);
      check("both_valid", bus.rd_valid, 0);

      // Reset during RD_ISSUE aborts the read
      bus.reg_rd   = 1'b1;
      bus.reg_addr = 8'h3B;
      @(negedge clk);
      bus.reg_rd = 1'b0;
      resetn     = 1'b0;
      #1;
      check("arst_busy", bus.busy, 0);
      check("arst_ce", bus.ram_ce, 0);
      check("arst_ad", bus.ram_ad, 0);
      check("arst_din", bus.ram_din, 0);
      check("arst_rdata", bus.reg_rdata, 0);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("arst_no_valid", bus.rd_valid, 0);
      end

      // Active-display guard
      bus.active_disp = 1'b1;
      bus_wr(8'h21, 8'h08);
      bus_wr(8'h22, 8'h01);
      bus_wr(8'h22, 8'h02);
`ifdef CGRAM_DISP_GUARD_EN
      check("guard_ce", s_ce, 0);
      @(negedge clk);
      check("guard_mem08", mem[8'h08], 15'h0000);
`else
      check("guard_ce", s_ce, 1);
      check("guard_ad", s_ad, 8'h08);
      check("guard_din", s_din, 15'h0201);
      @(negedge clk);
      check("guard_mem08", mem[8'h08], 15'h0201);
`endif
      bus.active_disp = 1'b0;
      bus_wr(8'h22, 8'h0A);
      bus_wr(8'h22, 8'h0B);
      check("guard_next_ad", s_ad, 8'h09);
      check("guard_next_din", s_din, 15'h0B0A);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cgram_cpu_port.md
# cgram_cpu_port

CPU-side access controller for the 256 x 15-bit palette RAM (CGRAM). It decodes the B-bus palette registers $2121 (CGADD), $2122 (CGDATA write) and $213B (CGDATA read). It assembles byte pairs into 15-bit colour words and drives port A of the dual-port CGRAM. The renderer reads the same RAM on port B.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `reg_wr`  in  1  one-cycle B-bus write strobe.
- `reg_rd`  in  1  one-cycle B-bus read strobe.
- `reg_addr`  in  8  low byte of the $21xx B-bus address.
- `reg_wdata`  in  8  write data.
- `open_bus`  in  8  PPU2 open-bus value; only bit 7 is used.
- `active_disp`  in  1  high during active display.
- `reg_rdata`  out  8  read data; held until the next capture.
- `rd_valid`  out  1  one-cycle pulse; `reg_rdata` is valid.
- `busy`  out  1  high while a read is in flight.
- `ram_ce`, `ram_wre`  out  1  port-A clock enable and write enable.
- `ram_ad`  out  8  port-A word address.
- `ram_din`  out  15  port-A write data.
- `ram_dout`  in  15  port-A read data; one-cycle read latency.
- `ram_oce`  out  1  tied to 1.

## Operation
- Internal state:
  - `cgadd[7:0]`: word address.
  - `flip`: 0 = low byte next.
  - `wlatch[7:0]`: held low byte.
  - FSM with states IDLE, RD_ISSUE, RD_CAPT.
- Strobes are accepted only in IDLE. Any strobe while `busy` is dropped and has no side effect.
- If `reg_wr` and `reg_rd` are both high, the write is taken and the read is dropped.
- Write to $21: `cgadd <= reg_wdata`, `flip <= 0`.
- Write to $22 with `flip=0`: `wlatch <= reg_wdata`, `flip <= 1`. No RAM access.
- Write to $22 with `flip=1`:
  - RAM write of `{reg_wdata[6:0], wlatch}` at `cgadd`.
  - `reg_wdata[7]` is discarded.
  - Then `cgadd <= cgadd+1`, mod 256, so 255 wraps to 0. `flip <= 0`.
- Read of $3B: IDLE → RD_ISSUE → RD_CAPT → IDLE.
  - RD_ISSUE drives a RAM read at `cgadd`.
  - RD_CAPT with `flip=0`: `reg_rdata <= ram_dout[7:0]`, `flip <= 1`.
  - RD_CAPT with `flip=1`: `reg_rdata <= {open_bus[7], ram_dout[14:8]}`, `flip <= 0`, `cgadd <= cgadd+1` with wrap.
- Reads and writes share `flip`; real-hardware interleaving quirks are intentional.
- Other addresses, and reads of $21/$22, are ignored with no state change.
- Reset values:
  - `cgadd`, `flip`, `wlatch`: 0.
  - `reg_rdata`: 0.
  - `rd_valid`, `busy`, `ram_ce`, `ram_wre`: 0.
  - `ram_ad`, `ram_din`: 0.
  - FSM: IDLE.
- Reset during a read aborts it; no `rd_valid` pulse is produced.

## Timing
- All outputs except `ram_oce` are registered.
- Write strobe at cycle N: `ram_ce=ram_wre=1` with `ram_ad`/`ram_din` during cycle N+1 only. `cgadd`/`flip` are updated from N+1.
- Read strobe at cycle N:
  - `busy=1` during N+1..N+2.
  - `ram_ce=1`, `ram_wre=0` during N+1.
  - `ram_dout` is valid in N+2 and is captured at the end of N+2.
  - `rd_valid=1` and the new `reg_rdata` appear in N+3, which is also the first cycle a new strobe is accepted.
- Read latency is 3 cycles, strobe to `rd_valid`.
- Back-to-back writes, one per cycle, are supported.
- `ram_ce=0` whenever no access is issued.

## Configuration
- `CGRAM_DISP_GUARD_EN` defined: a second $22 write while `active_disp=1` suppresses the RAM write (`ram_ce` stays 0). `cgadd` still increments and `flip` still clears.
- `CGRAM_DISP_GUARD_EN` undefined: `active_disp` is ignored and all writes reach RAM.

## Test plan
- Write $21=0x10, $22=0x1F, $22=0xFC → one RAM write at ad 0x10, din 0x7C1F. `cgadd`=0x11.
- Write $21=0xFF, then $22 pair 0x34, 0x12 → write at 0xFF, din 0x1234. `cgadd` wraps to 0x00.
- RAM[0x05]=0x7ABC, `open_bus`=0x80, $21=0x05, two $3B reads:
  - First read: `rdata`=0xBC.
  - Second read: `rdata`=0xFA.
  - Each `rd_valid` arrives 3 cycles after its strobe. `cgadd`=0x06.
- $22=0x11, then $21=0x20, then $22 pair 0x22, 0x33 → RAM[0x20]=0x3322. The first byte is discarded by the `flip` reset.
- `reg_wr` to $22 at cycle N+1 of a read → dropped. Deassert `resetn` in RD_ISSUE → no `rd_valid`, all outputs 0.
- With the macro, `active_disp=1`, $21=0x08, $22 pair 0x01, 0x02 → no RAM write, `cgadd`=0x09. Without the macro, RAM[0x08]=0x0201.
